fsmc_frontend: RTL and testbench
================================

// Module: fsmc_frontend
// PURPOSE
//  Front end for the STM32 FSMC multiplexed (AD16) bus, upstream of the Avalon
//  bus-master bridge. Synchronises the asynchronous FSMC strobes into avm_clk
//  and latches the address phase from the AD bus. Emits one-cycle rd_start/
//  wr_start pulses with addr/byte_en/data, and drives read data back onto AD.
// PARAMETERS
//  SYNC_STAGES  2             flops per strobe synchroniser (>=2)
//  ADDR_SHIFT   1             left shift of halfword address to byte address
//  BASE_ADDR    32'h0000_0000 ORed into the generated address
// PORTS
//  avm_clk      in   1   system clock
//  avm_reset    in   1   async reset, active-high
//  fsmc_ne      in   1   chip select, active-low, async
//  fsmc_noe     in   1   output enable (read strobe), active-low, async
//  fsmc_nwe     in   1   write enable, active-low, async
//  fsmc_nadv    in   1   address valid, active-low, async
//  fsmc_nbl     in   2   byte lane enables, active-low
//  fsmc_a_hi    in   8   A[23:16] address pins
//  fsmc_ad_in   in   16  AD bus input side
//  fsmc_ad_out  out  16  AD bus drive value (read data)
//  fsmc_ad_oe   out  1   AD bus tristate enable, 1=drive
//  rdata_in     in   16  read data returned by the bus-master bridge
//  ncs          out  1   synchronised chip select, active-low
//  rd_start     out  1   one-cycle read request pulse
//  wr_start     out  1   one-cycle write request pulse
//  addr         out  32  byte address of current access
//  byte_en      out  2   active-high byte enables
//  data_out     out  16  write data to bridge
// BEHAVIOUR
//  - Reset (avm_reset=1, async): state S_IDLE; ncs=1, rd_start=0, wr_start=0,
//    addr=BASE_ADDR, byte_en=0, data_out=0, fsmc_ad_out=0, fsmc_ad_oe=0;
//    all synchroniser flops preset to 1. Applies mid-access; no pulse follows.
//  - ne/noe/nwe/nadv each pass SYNC_STAGES flops -> ne_s/noe_s/nwe_s/nadv_s.
//    fsmc_ad_in and fsmc_nbl are registered once every cycle -> ad_q/nbl_q.
//  - ncs = ne_s.
//  - States: S_IDLE, S_CS, S_ADDR, S_ARMED, S_READ, S_WRITE, S_ERR.
//    S_IDLE : ne_s=0 -> S_CS.
//    S_CS   : nadv_s=0 -> S_ADDR.
//    S_ADDR : ad_lat<=ad_q every cycle; nadv_s=1 -> S_ARMED.
//    S_ARMED: noe_s=0 & nwe_s=1 -> S_READ; nwe_s=0 & noe_s=1 -> S_WRITE;
//             both 0 -> S_ERR (no pulse).
//    S_READ : noe_s=1 -> S_CS.   S_WRITE: nwe_s=1 -> S_CS.
//    S_ERR  : noe_s=1 & nwe_s=1 -> S_CS.
//    Any state: ne_s=1 -> S_IDLE (takes priority over all other transitions).
//  - addr = BASE_ADDR | ({fsmc_a_hi, ad_lat} << ADDR_SHIFT), 32-bit result,
//    upper bits zero-filled; updated on the ARMED->READ/WRITE transition.
//  - rd_start=1 exactly in the first cycle of S_READ; wr_start=1 exactly in
//    the first cycle of S_WRITE. Latency raw strobe fall -> pulse:
//    SYNC_STAGES+1 clocks. Strobe held low any length -> exactly one pulse.
//  - On ARMED->WRITE: data_out<=ad_q, byte_en<=~nbl_q; both valid with wr_start.
//    On ARMED->READ: byte_en<=~nbl_q, data_out unchanged.
//  - fsmc_ad_out <= rdata_in every cycle while in S_READ.
//  - fsmc_ad_oe = (state==S_READ) & ~fsmc_noe & ~fsmc_ne.
//    Uses the raw pins so the bus releases within combinational delay of NOE/NE
//    rising. The FSMC DATAST setting covers bridge latency; the bridge's wait_out
//    handles stalls.
//  - FSMC timing requirement: ADDSET and ADDHLD each >= SYNC_STAGES+2 avm_clk
//    cycles, so ad_q is stable while latched.
//  - NE rising mid-access: return to S_IDLE, oe drops. A pulse already issued
//    is not retracted.
// TESTING
//  - Write: a_hi=0x05, AD addr 0x1234, NWE low with AD=0xBEEF, nbl=00 ->
//    single wr_start, addr=0x000A2468, data_out=0xBEEF, byte_en=11.
//  - Read: AD addr 0x0010, NOE low, rdata_in=0x5A5A -> single rd_start,
//    addr=0x00000020, fsmc_ad_out=0x5A5A, oe=1. NOE rising -> oe=0 combinationally.
//  - Byte write, nbl=10 -> byte_en=01. Back-to-back accesses under one NE low,
//    each with its own NADV -> two pulses, each with its own correct address.
//  - NOE and NWE both low in S_ARMED -> no rd_start/wr_start, S_ERR until both high.
//  - NWE held low 50 clocks -> exactly one wr_start, at SYNC_STAGES+1 clocks
//    after NWE falls.
//  - avm_reset pulsed during S_READ -> oe=0 and all outputs at reset values
//    immediately. No pulse until a new NE/NADV sequence.

Source files
------------

// File: rtl/fsmc_frontend_if.sv
// FSMC pin bundle plus the bridge-facing request/response signals of the front end.
// The slave modport is the front end; the master modport is the FSMC host and bridge side.
interface fsmc_frontend_if;
    logic        fsmc_ne;
    logic        fsmc_noe;
    logic        fsmc_nwe;
    logic        fsmc_nadv;
    logic [1:0]  fsmc_nbl;
    logic [7:0]  fsmc_a_hi;
    logic [15:0] fsmc_ad_in;
    logic [15:0] fsmc_ad_out;
    logic        fsmc_ad_oe;
    logic [15:0] rdata_in;
    logic        ncs;
    logic        rd_start;
    logic        wr_start;
    logic [31:0] addr;
    logic [1:0]  byte_en;
    logic [15:0] data_out;

    modport slave (
        input  fsmc_ne, fsmc_noe, fsmc_nwe, fsmc_nadv, fsmc_nbl, fsmc_a_hi,
               fsmc_ad_in, rdata_in,
        output fsmc_ad_out, fsmc_ad_oe, ncs, rd_start, wr_start, addr,
               byte_en, data_out
    );

    modport master (
        output fsmc_ne, fsmc_noe, fsmc_nwe, fsmc_nadv, fsmc_nbl, fsmc_a_hi,
               fsmc_ad_in, rdata_in,
        input  fsmc_ad_out, fsmc_ad_oe, ncs, rd_start, wr_start, addr,
               byte_en, data_out
    );
endinterface

// File: rtl/fsmc_frontend.sv
// STM32 FSMC AD16 front end: synchronises strobes, latches the address phase and
// issues one-cycle rd/wr start pulses SYNC_STAGES+1 clocks after a strobe falls.
module fsmc_frontend #(
    parameter int          SYNC_STAGES = 2,
    parameter int          ADDR_SHIFT  = 1,
    parameter logic [31:0] BASE_ADDR   = 32'h0000_0000
) (
    input  logic            avm_clk,
    input  logic            avm_reset,
    fsmc_frontend_if.slave  bus_io
);

    typedef enum logic [2:0] {
        S_IDLE, S_CS, S_ADDR, S_ARMED, S_READ, S_WRITE, S_ERR
    } state_t;

    state_t state_q, state_d;

    logic [SYNC_STAGES-1:0] ne_sync_q, noe_sync_q, nwe_sync_q, nadv_sync_q;
    logic                   ne_s, noe_s, nwe_s, nadv_s;
    logic [15:0]            ad_q, ad_lat_q;
    logic [1:0]             nbl_q;
    logic                   rd_fire, wr_fire;
    logic [31:0]            addr_calc;

    logic                   rd_start_q, wr_start_q;
    logic [31:0]            addr_q;
    logic [1:0]             byte_en_q;
    logic [15:0]            data_out_q, ad_out_q;

    // Presetting the synchronisers to 1 makes every strobe read as inactive out of reset.
    always_ff @(posedge avm_clk or posedge avm_reset) begin
        if (avm_reset) begin
            ne_sync_q   <= '1;
            noe_sync_q  <= '1;
            nwe_sync_q  <= '1;
            nadv_sync_q <= '1;
            ad_q        <= '0;
            nbl_q       <= '0;
        end else begin
            ne_sync_q   <= {ne_sync_q[SYNC_STAGES-2:0],   bus_io.fsmc_ne};
            noe_sync_q  <= {noe_sync_q[SYNC_STAGES-2:0],  bus_io.fsmc_noe};
            nwe_sync_q  <= {nwe_sync_q[SYNC_STAGES-2:0],  bus_io.fsmc_nwe};
            nadv_sync_q <= {nadv_sync_q[SYNC_STAGES-2:0], bus_io.fsmc_nadv};
            ad_q        <= bus_io.fsmc_ad_in;
            nbl_q       <= bus_io.fsmc_nbl;
        end
    end

    assign ne_s   = ne_sync_q[SYNC_STAGES-1];
    assign noe_s  = noe_sync_q[SYNC_STAGES-1];
    assign nwe_s  = nwe_sync_q[SYNC_STAGES-1];
    assign nadv_s = nadv_sync_q[SYNC_STAGES-1];

    assign addr_calc = BASE_ADDR | (32'({bus_io.fsmc_a_hi, ad_lat_q}) << ADDR_SHIFT);

    always_ff @(posedge avm_clk or posedge avm_reset) begin
        if (avm_reset) state_q <= S_IDLE;
        else           state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        rd_fire = 1'b0;
        wr_fire = 1'b0;
        if (ne_s) begin
            state_d = S_IDLE;
        end else begin
            case (state_q)
                S_IDLE:  state_d = S_CS;
                S_CS:    if (!nadv_s) state_d = S_ADDR;
                S_ADDR:  if (nadv_s)  state_d = S_ARMED;
                S_ARMED: begin
                    if (!noe_s && nwe_s) begin
                        state_d = S_READ;
                        rd_fire = 1'b1;
                    end else if (!nwe_s && noe_s) begin
                        state_d = S_WRITE;
                        wr_fire = 1'b1;
                    end else if (!noe_s && !nwe_s) begin
                        state_d = S_ERR;
                    end
                end
                S_READ:  if (noe_s)  state_d = S_CS;
                S_WRITE: if (nwe_s)  state_d = S_CS;
                S_ERR:   if (noe_s && nwe_s) state_d = S_CS;
                default: state_d = S_IDLE;
            endcase
        end
    end

    // Pulses are registered on the ARMED exit, so they land in the first cycle of READ/WRITE.
    always_ff @(posedge avm_clk or posedge avm_reset) begin
        if (avm_reset) begin
            rd_start_q <= 1'b0;
            wr_start_q <= 1'b0;
            addr_q     <= BASE_ADDR;
            byte_en_q  <= '0;
            data_out_q <= '0;
            ad_out_q   <= '0;
            ad_lat_q   <= '0;
        end else begin
            rd_start_q <= rd_fire;
            wr_start_q <= wr_fire;
            if (state_q == S_ADDR)
                ad_lat_q <= ad_q;
            if (rd_fire || wr_fire) begin
                addr_q    <= addr_calc;
                byte_en_q <= ~nbl_q;
            end
            if (wr_fire)
                data_out_q <= ad_q;
            if (state_q == S_READ)
                ad_out_q <= bus_io.rdata_in;
        end
    end

    assign bus_io.ncs         = ne_s;
    assign bus_io.rd_start    = rd_start_q;
    assign bus_io.wr_start    = wr_start_q;
    assign bus_io.addr        = addr_q;
    assign bus_io.byte_en     = byte_en_q;
    assign bus_io.data_out    = data_out_q;
    assign bus_io.fsmc_ad_out = ad_out_q;
    // Raw pins so the AD bus is released within gate delay of NOE/NE rising.
    assign bus_io.fsmc_ad_oe  = (state_q == S_READ) & ~bus_io.fsmc_noe & ~bus_io.fsmc_ne;

endmodule

// File: tb/tb_fsmc_frontend.sv
// Bench for fsmc_frontend: host-level FSMC transactions checked against a
// transaction model (address arithmetic, pulse count and pulse timing).
module tb_fsmc_frontend;
    logic avm_clk = 1'b0;
    logic avm_reset;

    fsmc_frontend_if bus ();

    fsmc_frontend #(
        .SYNC_STAGES (2),
        .ADDR_SHIFT  (1),
        .BASE_ADDR   (32'h0000_0000)
    ) dut (
        .avm_clk   (avm_clk),
        .avm_reset (avm_reset),
        .bus_io    (bus)
    );

    always #5 avm_clk = ~avm_clk;

    localparam int LAT = 3;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    typedef struct {
        bit          is_wr;
        int          cyc;
        logic [31:0] addr;
        logic [1:0]  be;
        logic [15:0] data;
    } pulse_t;

    pulse_t      pq[$];
    logic [15:0] model_wdata = 16'h0000;

    always @(posedge avm_clk) begin
        cyc++;
        #1;
        if (bus.rd_start === 1'b1)
            pq.push_back('{is_wr: 1'b0, cyc: cyc, addr: bus.addr, be: bus.byte_en, data: bus.data_out});
        if (bus.wr_start === 1'b1)
            pq.push_back('{is_wr: 1'b1, cyc: cyc, addr: bus.addr, be: bus.byte_en, data: bus.data_out});
    end

    function automatic logic [31:0] model_addr(input logic [7:0] a_hi, input logic [15:0] ad);
        int unsigned halfword;
        halfword = int'(a_hi) * 65536 + int'(ad);
        return 32'h0000_0000 | (halfword * 2);
    endfunction

    task automatic tick(input int n);
        repeat (n) @(negedge avm_clk);
    endtask

    task automatic ne_low();
        bus.fsmc_ne = 1'b0;
        tick(4);
    endtask

    task automatic ne_high();
        bus.fsmc_ne = 1'b1;
        tick(4);
    endtask

    task automatic addr_phase(input logic [7:0] a_hi, input logic [15:0] ad);
        bus.fsmc_a_hi  = a_hi;
        bus.fsmc_ad_in = ad;
        bus.fsmc_nadv  = 1'b0;
        tick(6);
        bus.fsmc_nadv  = 1'b1;
        tick(6);
    endtask

    task automatic access(input bit is_wr, input logic [7:0] a_hi, input logic [15:0] ad,
                          input logic [15:0] wdata, input logic [1:0] nbl,
                          input logic [15:0] rdata, input int hold, input string name);
        int          fall;
        logic [1:0]  exp_be;
        logic [15:0] exp_data;
        logic [31:0] exp_addr;
        exp_be   = ~nbl;
        exp_addr = model_addr(a_hi, ad);
        exp_data = is_wr ? wdata : model_wdata;
        pq.delete();
        addr_phase(a_hi, ad);
        bus.fsmc_nbl   = nbl;
        bus.fsmc_ad_in = is_wr ? wdata : 16'($urandom);
        bus.rdata_in   = rdata;
        fall = cyc;
        if (is_wr) bus.fsmc_nwe = 1'b0;
        else       bus.fsmc_noe = 1'b0;
        tick(hold);
        if (!is_wr) begin
            checks++;
            if (bus.fsmc_ad_oe !== 1'b1) begin
                errors++;
                $display("FAIL %s oe_during_read: got %b expected 1", name, bus.fsmc_ad_oe);
            end
            checks++;
            if (bus.fsmc_ad_out !== rdata) begin
                errors++;
                $display("FAIL %s ad_out: got %h expected %h", name, bus.fsmc_ad_out, rdata);
            end
            bus.fsmc_noe = 1'b1;
            #1;
            checks++;
            if (bus.fsmc_ad_oe !== 1'b0) begin
                errors++;
                $display("FAIL %s oe_release: got %b expected 0", name, bus.fsmc_ad_oe);
            end
        end else begin
            bus.fsmc_nwe = 1'b1;
        end
        tick(5);
        checks++;
        if (pq.size() != 1) begin
            errors++;
            $display("FAIL %s pulse_count: got %0d expected 1", name, pq.size());
        end
        if (pq.size() >= 1) begin
            checks++;
            if (pq[0].is_wr !== is_wr || pq[0].cyc != fall + LAT) begin
                errors++;
                $display("FAIL %s pulse_kind_cycle: got wr=%b cyc=%0d expected wr=%b cyc=%0d",
                         name, pq[0].is_wr, pq[0].cyc, is_wr, fall + LAT);
            end
            checks++;
            if (pq[0].addr !== exp_addr || pq[0].be !== exp_be || pq[0].data !== exp_data) begin
                errors++;
                $display("FAIL %s pulse_fields: got addr=%h be=%b data=%h expected addr=%h be=%b data=%h",
                         name, pq[0].addr, pq[0].be, pq[0].data, exp_addr, exp_be, exp_data);
            end
        end
        if (is_wr) model_wdata = wdata;
    endtask

    task automatic test_reset();
        avm_reset      = 1'b1;
        bus.fsmc_ne    = 1'b1;
        bus.fsmc_noe   = 1'b1;
        bus.fsmc_nwe   = 1'b1;
        bus.fsmc_nadv  = 1'b1;
        bus.fsmc_nbl   = 2'b11;
        bus.fsmc_a_hi  = 8'h00;
        bus.fsmc_ad_in = 16'h0000;
        bus.rdata_in   = 16'h0000;
        tick(3);
        checks++;
        if (bus.ncs !== 1'b1 || bus.rd_start !== 1'b0 || bus.wr_start !== 1'b0 ||
            bus.addr !== 32'h0 || bus.byte_en !== 2'b00 || bus.data_out !== 16'h0 ||
            bus.fsmc_ad_out !== 16'h0 || bus.fsmc_ad_oe !== 1'b0) begin
            errors++;
            $display("FAIL reset_values: got ncs=%b rd=%b wr=%b addr=%h be=%b dout=%h adout=%h oe=%b expected 1 0 0 0 0 0 0 0",
                     bus.ncs, bus.rd_start, bus.wr_start, bus.addr, bus.byte_en,
                     bus.data_out, bus.fsmc_ad_out, bus.fsmc_ad_oe);
        end
        avm_reset = 1'b0;
        tick(4);
        checks++;
        if (bus.ncs !== 1'b1) begin
            errors++;
            $display("FAIL ncs_idle: got %b expected 1", bus.ncs);
        end
    endtask

    task automatic test_write();
        ne_low();
        checks++;
        if (bus.ncs !== 1'b0) begin
            errors++;
            $display("FAIL ncs_active: got %b expected 0", bus.ncs);
        end
        access(1'b1, 8'h05, 16'h1234, 16'hBEEF, 2'b00, 16'h0000, 8, "write");
        checks++;
        if (bus.addr !== 32'h000A_2468) begin
            errors++;
            $display("FAIL write_addr_const: got %h expected 000a2468", bus.addr);
        end
        ne_high();
    endtask

    task automatic test_read();
        ne_low();
        access(1'b0, 8'h00, 16'h0010, 16'h0000, 2'b00, 16'h5A5A, 8, "read");
        ne_high();
    endtask

    task automatic test_byte_write();
        ne_low();
        access(1'b1, 8'h3C, 16'h00FF, 16'h00A5, 2'b10, 16'h0000, 6, "byte_write");
        ne_high();
    endtask

    task automatic test_back_to_back();
        ne_low();
        access(1'b1, 8'h12, 16'h4000, 16'h1357, 2'b01, 16'h0000, 6, "b2b_first");
        access(1'b0, 8'h7F, 16'hFFFF, 16'h0000, 2'b00, 16'hC0DE, 6, "b2b_second");
        ne_high();
    endtask

    task automatic test_err();
        ne_low();
        pq.delete();
        addr_phase(8'h01, 16'h0002);
        bus.fsmc_noe = 1'b0;
        bus.fsmc_nwe = 1'b0;
        tick(10);
        checks++;
        if (bus.fsmc_ad_oe !== 1'b0 || pq.size() != 0) begin
            errors++;
            $display("FAIL err_both_low: got oe=%b pulses=%0d expected oe=0 pulses=0", bus.fsmc_ad_oe, pq.size());
        end
        bus.fsmc_noe = 1'b1;
        tick(6);
        bus.fsmc_noe = 1'b0;
        tick(6);
        checks++;
        if (bus.fsmc_ad_oe !== 1'b0 || pq.size() != 0) begin
            errors++;
            $display("FAIL err_hold_nwe: got oe=%b pulses=%0d expected oe=0 pulses=0", bus.fsmc_ad_oe, pq.size());
        end
        bus.fsmc_noe = 1'b1;
        bus.fsmc_nwe = 1'b1;
        tick(5);
        access(1'b1, 8'h02, 16'h0100, 16'h2222, 2'b00, 16'h0000, 6, "after_err");
        ne_high();
    endtask

    task automatic test_long_nwe();
        ne_low();
        access(1'b1, 8'hA0, 16'h8001, 16'h4B1D, 2'b00, 16'h0000, 50, "long_nwe");
        ne_high();
    endtask

    task automatic test_reset_mid_read();
        ne_low();
        addr_phase(8'h00, 16'h0040);
        bus.rdata_in = 16'h9999;
        bus.fsmc_noe = 1'b0;
        tick(6);
        checks++;
        if (bus.fsmc_ad_oe !== 1'b1) begin
            errors++;
            $display("FAIL rst_read_oe: got %b expected 1", bus.fsmc_ad_oe);
        end
        pq.delete();
        avm_reset = 1'b1;
        #1;
        checks++;
        if (bus.fsmc_ad_oe !== 1'b0 || bus.fsmc_ad_out !== 16'h0 || bus.addr !== 32'h0 ||
            bus.byte_en !== 2'b00 || bus.data_out !== 16'h0 || bus.ncs !== 1'b1 ||
            bus.rd_start !== 1'b0 || bus.wr_start !== 1'b0) begin
            errors++;
            $display("FAIL rst_mid_read: got oe=%b adout=%h addr=%h be=%b dout=%h ncs=%b expected 0 0 0 0 0 1",
                     bus.fsmc_ad_oe, bus.fsmc_ad_out, bus.addr, bus.byte_en, bus.data_out, bus.ncs);
        end
        tick(2);
        avm_reset = 1'b0;
        tick(10);
        checks++;
        if (pq.size() != 0 || bus.fsmc_ad_oe !== 1'b0) begin
            errors++;
            $display("FAIL rst_no_pulse: got pulses=%0d oe=%b expected 0 0", pq.size(), bus.fsmc_ad_oe);
        end
        bus.fsmc_noe = 1'b1;
        ne_high();
        model_wdata = 16'h0000;
    endtask

    task automatic test_random();
        for (int i = 0; i < 10; i++) begin
            bit          wr;
            logic [7:0]  a_hi;
            logic [15:0] ad;
            logic [15:0] wd;
            logic [15:0] rd;
            logic [1:0]  nbl;
            int          hold;
            wr   = 1'($urandom);
            a_hi = 8'($urandom);
            ad   = 16'($urandom);
            wd   = 16'($urandom);
            rd   = 16'($urandom);
            nbl  = 2'($urandom);
            hold = int'($urandom_range(5, 20));
            ne_low();
            access(wr, a_hi, ad, wd, nbl, rd, hold, "random");
            ne_high();
        end
    endtask

    initial begin
        test_reset();
        test_write();
        test_read();
        test_byte_write();
        test_back_to_back();
        test_err();
        test_long_nwe();
        test_reset_mid_read();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
